// File: rtl/alu_operand_stage_pkg.sv
// Shared constants for the ALU operand path: datapath width, register
// index width, register count and the hardwired-zero register index.
package alu_operand_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : alu_operand_stage_pkg

// File: rtl/alu_operand_stage_regfile_2r1w.sv
// Architectural register file: two read ports, one write port, r0 hardwired
// to zero, and write-to-read bypass so a same-cycle write-back is visible.
module alu_operand_stage_regfile_2r1w
  import alu_operand_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              wb_live_s;

  assign wb_live_s = wb_en && (wb_addr != ZERO_REG);

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] rs,
    input logic              wb_live,
    input logic [ADDR_W-1:0] wb_idx,
    input logic [DATA_W-1:0] wb_val,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (rs == ZERO_REG) begin
      val = {DATA_W{1'b0}};
    end else if (wb_live && (wb_idx == rs)) begin
      val = wb_val;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Register storage; r0 is never written so it stays zero after reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_live_s) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Read muxes with zero-register and write-back bypass.
  always_comb begin
    rd_a = read_port(rs_a, wb_live_s, wb_addr, wb_data, regs_r[rs_a]);
    rd_b = read_port(rs_b, wb_live_s, wb_addr, wb_data, regs_r[rs_b]);
  end

endmodule : alu_operand_stage_regfile_2r1w

// File: rtl/alu_operand_stage.sv
// Operand stage: register file plus a one-entry valid/ready pipeline register
// whose held operands track later write-backs while the ALU stalls.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  logic [DATA_W-1:0] rd_a_s, rd_b_s;
  logic [DATA_W-1:0] a_r, b_r, a_nxt_s, b_nxt_s;
  logic [ADDR_W-1:0] held_a_r, held_b_r, held_a_nxt_s, held_b_nxt_s;
  logic              out_valid_r, out_valid_nxt_s;
  logic              acc_s, stall_s, wb_live_s;

  alu_operand_stage_regfile_2r1w u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .rs_a    (rs_a),
    .rs_b    (rs_b),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rd_a    (rd_a_s),
    .rd_b    (rd_b_s)
  );

  assign in_ready  = ~out_valid_r | out_ready;
  assign acc_s     = in_valid & in_ready;
  assign stall_s   = out_valid_r & ~out_ready;
  assign wb_live_s = wb_en && (wb_addr != ZERO_REG);

  // Next-state for the operand register: accept wins, else refresh on stall.
  always_comb begin
    a_nxt_s         = a_r;
    b_nxt_s         = b_r;
    held_a_nxt_s    = held_a_r;
    held_b_nxt_s    = held_b_r;
    out_valid_nxt_s = out_valid_r;
    if (acc_s) begin
      a_nxt_s         = rd_a_s;
      b_nxt_s         = rd_b_s;
      held_a_nxt_s    = rs_a;
      held_b_nxt_s    = rs_b;
      out_valid_nxt_s = 1'b1;
    end else if (stall_s) begin
      if (wb_live_s && (wb_addr == held_a_r)) begin
        a_nxt_s = wb_data;
      end else begin
        a_nxt_s = a_r;
      end
      if (wb_live_s && (wb_addr == held_b_r)) begin
        b_nxt_s = wb_data;
      end else begin
        b_nxt_s = b_r;
      end
    end else begin
      // Drain (or idle): A/B keep stale contents, valid drops.
      out_valid_nxt_s = 1'b0;
    end
  end

  // Operand pipeline register with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_r         <= {DATA_W{1'b0}};
      b_r         <= {DATA_W{1'b0}};
      held_a_r    <= ZERO_REG;
      held_b_r    <= ZERO_REG;
      out_valid_r <= 1'b0;
    end else begin
      a_r         <= a_nxt_s;
      b_r         <= b_nxt_s;
      held_a_r    <= held_a_nxt_s;
      held_b_r    <= held_b_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign out_valid = out_valid_r;
  assign A         = a_r;
  assign B         = b_r;

endmodule : alu_operand_stage

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against an
// architectural model: held operands always equal the current register value.
module tb_alu_operand_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs_a = 5'd0;
  logic [4:0]  rs_b = 5'd0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] A;
  logic [31:0] B;

  int errors = 0;
  int checks = 0;

  // Architectural model: register values plus the pending pair's sources.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [4:0]  m_src_a, m_src_b;
  int          n_acc, n_cons, n_valid_cycles;

  alu_operand_stage dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs_a      (rs_a),
    .rs_b      (rs_b),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .B         (B)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic step(input logic rstn, input logic iv, input logic [4:0] ra,
                      input logic [4:0] rb, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ordy);
    logic acc;
    reset_n = rstn; in_valid = iv; rs_a = ra; rs_b = rb;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid) || ordy});
    if (rstn) begin
      if (iv && in_ready) n_acc++;
      if (out_valid && ordy) n_cons++;
    end
    if (!rstn) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 1'b0; m_src_a = 5'd0; m_src_b = 5'd0;
    end else begin
      acc = iv && (!m_valid || ordy);
      if (we && wa != 5'd0) m_regs[wa] = wd;
      if (acc) begin
        m_valid = 1'b1; m_src_a = ra; m_src_b = rb;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      n_valid_cycles++;
      check_eq("A_model", A, m_regs[m_src_a]);
      check_eq("B_model", B, m_regs[m_src_b]);
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, ordy);
  endtask

  initial begin
    logic [31:0] b_before;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_src_a = 5'd0; m_src_b = 5'd0;
    n_acc = 0; n_cons = 0; n_valid_cycles = 0;
    @(negedge clock);

    // Reset for two cycles with a write-back to r5 that must be ignored.
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h5555_5555, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h5555_5555, 1'b0);
    check_eq("rst_A", A, 32'd0);
    check_eq("rst_B", B, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1);
    check_eq("rst_r5", A, 32'd0);
    idle(1'b1);

    // Basic read.
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    check_eq("basic_valid", {31'd0, out_valid}, 32'd1);
    check_eq("basic_A", A, 32'hDEAD_BEEF);
    check_eq("basic_B", B, 32'd0);

    // Zero register ignores writes.
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    check_eq("zero_A", A, 32'd0);

    // Same-cycle bypass.
    step(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h1234_5678, 1'b1);
    check_eq("bypass_A", A, 32'h1234_5678);
    check_eq("bypass_B", B, 32'h1234_5678);
    idle(1'b1);

    // Stall with hold refresh of A only.
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'd1, 1'b1);
    step(1'b1, 1'b1, 5'd4, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    check_eq("stall_A0", A, 32'd1);
    b_before = B;
    step(1'b1, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd4, 32'h0000_00AA, 1'b0);
    check_eq("refresh_A", A, 32'h0000_00AA);
    check_eq("stall_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    check_eq("refresh_A_hold", A, 32'h0000_00AA);
    check_eq("stall_B", B, b_before);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back throughput: eight pairs, one per cycle, in order.
    for (int i = 1; i <= 8; i++)
      step(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'(100 + i), 1'b1);
    n_valid_cycles = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 5'(i), 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
      check_eq("tput_A", A, 32'(100 + i));
    end
    idle(1'b1);
    check_eq("tput_pairs", 32'(n_valid_cycles), 32'd8);

    // Toggled out_ready: every accepted pair is consumed exactly once.
    n_acc = 0; n_cons = 0;
    for (int i = 0; i < 12; i++)
      step(1'b1, 1'b1, 5'(i % 8 + 1), 5'(8 - i % 8), 1'b0, 5'd0, 32'd0, 1'(i % 2));
    idle(1'b1);
    idle(1'b1);
    check_eq("toggle_balance", 32'(n_acc), 32'(n_cons));

    // Reset in the middle of a stream.
    step(1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 32'h0BAD_0BAD, 1'b1);
    check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 1'b1, 5'd1, 5'd8, 1'b0, 5'd0, 32'd0, 1'b1);
    check_eq("midrst_r1", A, 32'd0);

    // Randomized traffic; addresses mostly in a small window to force hits.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] ra, rb, wa;
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      step(($urandom_range(0, 99) != 0), 1'($urandom), ra, rb,
           ($urandom_range(0, 2) != 0), wa, $urandom, ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_alu_operand_stage

// File: doc/alu_operand_stage.md
# alu_operand_stage

Register file and operand pipeline register directly upstream of the ALU bitwise/arithmetic units. It holds the 32 architectural registers, reads two source operands per accepted instruction, and presents them on registered A/B buses to the ALU with a valid/ready handshake. Write-back is accepted every cycle, with same-cycle bypass into the read path. Held operands stay coherent with later write-backs while the ALU stalls.

## Interface
- DATA_W, 32, operand/register width (ALU bitwise units are 32-bit; fixed at 32 in this design)
- ADDR_W, 5, register index width; register count = 2**ADDR_W
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream offers rs_a/rs_b
- in_ready  out  1  stage can accept this cycle
- rs_a  in  ADDR_W  source register for A
- rs_b  in  ADDR_W  source register for B
- wb_en  in  1  write-back strobe
- wb_addr  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back value
- out_valid  out  1  A/B hold a valid operand pair
- out_ready  in  1  ALU consumes A/B this cycle
- A  out  DATA_W  operand A to ALU
- B  out  DATA_W  operand B to ALU

## Operation
- Register 0 reads as 0 always. Writes to register 0 are dropped.
- Write: wb_en=1 and wb_addr!=0 updates regs[wb_addr] at the clock edge. Write-back is never back-pressured.
- Read with bypass:
  - rd_x = 0 if rs_x==0.
  - Else rd_x = wb_data if wb_en and wb_addr==rs_x.
  - Else rd_x = regs[rs_x].
- Accept: acc = in_valid & in_ready. On acc:
  - A<=rd_a, B<=rd_b.
  - Latch rs_a/rs_b into held_a/held_b.
  - out_valid<=1.
- in_ready = ~out_valid | out_ready. This is a one-entry pipeline register with full throughput.
- Drain: out_valid & out_ready & ~acc clears out_valid. A/B keep their last values, but their contents are don't-care.
- Hold refresh: while out_valid & ~out_ready, a write-back with wb_en, wb_addr!=0 and wb_addr==held_a updates A to wb_data next edge. The same rule applies to B. If held_a==held_b, both are updated.
- Precedence: acc beats hold refresh. Accepted data already includes bypass.

## Timing
- Reset (reset_n=0 at edge): all regs=0, A=0, B=0, held_a=held_b=0, out_valid=0. in_ready=1 after reset.
- Reset mid-operation discards the held pair and all register contents. Write-back in the reset cycle is ignored.
- Latency: operands appear on A/B one cycle after acc. Sustained one pair per cycle when out_ready=1.
- A write in cycle N is visible to a read accepted in cycle N (bypass) and every later cycle.
- Simultaneous write-back, accept and drain in one cycle are all legal and independent.
- A/B change only on acc, hold refresh, or reset. They are stable while out_valid & ~out_ready, except for refresh.
- in_ready is combinational from out_valid/out_ready only; no path from in_valid.

## Structure
- Shared package holds DATA_W=32, ADDR_W=5, NUM_REGS=32 and the zero-register index constant. The ALU and its bitwise units use these same constants.
- One natural sub-module: regfile_2r1w (storage, r0 hardwiring, write-bypass read muxes).
- The top level adds the handshake register, held indices and refresh logic.

## Test plan
- Reset: drive reset_n=0 for 2 cycles with wb_en=1 to r5 -> out_valid=0, A=B=0, in_ready=1. A subsequent read of r5 returns 0.
- Basic read: write r3=0xDEADBEEF, then accept rs_a=3, rs_b=0 -> next cycle out_valid=1, A=0xDEADBEEF, B=0.
- Zero register: wb r0=0xFFFFFFFF, accept rs_a=0 -> A=0.
- Bypass: same cycle wb r7=0x12345678 and accept rs_a=7, rs_b=7 -> A=B=0x12345678.
- Stall and refresh:
  - Accept rs_a=4 (r4=1), hold out_ready=0 for 3 cycles and wb r4=0xAA in stall cycle 2 -> A=0xAA from next edge.
  - in_ready=0 throughout the stall; B is unchanged.
- Throughput and back-to-back: out_ready=1, in_valid=1 for 8 cycles with rs_a=1..8 -> 8 pairs, one per cycle, in order.
  - Toggle out_ready each cycle -> no pair dropped or duplicated.
  - Assert reset_n=0 mid-stream -> out_valid=0 next cycle.
